// File: rtl/ins_fetch_ctrl_pkg.sv
// Shared definitions for the core fetch controllers: state encoding and default widths.
package ins_fetch_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_INS_WIDTH  = 9;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      RESP   = 3'd2,
      HOLD   = 3'd3,
      HALTED = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the synchronous instruction memory
// and hands each fetched instruction to the decoder over valid/ready.
module ins_fetch_ctrl
   import ins_fetch_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    INS_WIDTH  = DEF_INS_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] flush_target,
   input  logic                  halt,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic [ADDR_WIDTH-1:0] PC_address,
   output logic                  rEn,
   input  logic [INS_WIDTH-1:0]  mem_instruction,
   output logic                  ins_valid,
   input  logic                  ins_ready,
   output logic [INS_WIDTH-1:0]  instruction,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  busy,
   output logic                  pc_wrap,
   output logic [CNT_WIDTH-1:0]  fetch_count
);

   fetch_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next;
   logic                  active;
   logic                  start_act;
   logic                  flush_act;
   logic                  handshake;

   assign active    = (state == REQ) || (state == RESP) || (state == HOLD);
   assign start_act = start && ((state == IDLE) || (state == HALTED));
   assign flush_act = flush && active;
   assign handshake = (state == HOLD) && ins_ready && !flush_act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // Flush overrides whatever the per-state logic chose, including a handshake.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      rEn        = 1'b0;
      ins_valid  = 1'b0;
      busy       = active;
      PC_address = pc;
      case (state)
         IDLE, HALTED: begin
            if (start) begin
               state_next = REQ;
               pc_next    = RESET_PC;
            end
         end
         REQ: begin
            rEn        = 1'b1;
            state_next = RESP;
         end
         RESP: state_next = HOLD;
         HOLD: begin
            ins_valid = 1'b1;
            if (ins_ready) begin
               if (halt) begin
                  state_next = HALTED;
               end else if (branch_en) begin
                  state_next = REQ;
                  pc_next    = branch_target;
               end else begin
                  state_next = REQ;
                  pc_next    = pc + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush_act) begin
         state_next = REQ;
         pc_next    = flush_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= '0;
         pc_out      <= '0;
      end else if ((state == RESP) && !flush_act) begin
         instruction <= mem_instruction;
         pc_out      <= pc;
      end
   end

   // Wrap is flagged only on a sequential step; a branch to 0 is not a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
         pc_wrap     <= 1'b0;
      end else if (start_act) begin
         fetch_count <= '0;
         pc_wrap     <= 1'b0;
      end else if (handshake) begin
         if (fetch_count != '1) begin
            fetch_count <= fetch_count + 1'b1;
         end
         if (!halt && !branch_en && (pc == '1)) begin
            pc_wrap <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Self-checking bench for ins_fetch_ctrl: directed scenarios plus randomized traffic
// checked against a transaction/timing reference model.
module tb_ins_fetch_ctrl;

   localparam int AW = 8;
   localparam int IW = 9;
   localparam int CW = 4;
   localparam int CNT_MAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, flush, halt, branch_en, ins_ready;
   logic [AW-1:0] flush_target, branch_target;
   logic [AW-1:0] PC_address, pc_out;
   logic          rEn, ins_valid, busy, pc_wrap;
   logic [IW-1:0] mem_instruction, instruction;
   logic [CW-1:0] fetch_count;

   logic [IW-1:0] mem [0:255];
   int            checks = 0;
   int            failures = 0;

   // Reference model: next fetch address, pending fetch/presentation deadlines, counters.
   bit            m_active, m_need, m_pending, m_wrap;
   int            m_cyc, m_fetch_due, m_valid_due, m_count;
   logic [AW-1:0] m_pc, m_fetched;

   ins_fetch_ctrl #(.ADDR_WIDTH(AW), .INS_WIDTH(IW), .RESET_PC(8'h00), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .flush_target(flush_target),
      .halt(halt), .branch_en(branch_en), .branch_target(branch_target),
      .PC_address(PC_address), .rEn(rEn), .mem_instruction(mem_instruction),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .instruction(instruction),
      .pc_out(pc_out), .busy(busy), .pc_wrap(pc_wrap), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rEn) mem_instruction <= mem[PC_address];
   end

   // Model checks at the falling edge, then consumes the inputs for the next rising edge.
   always @(negedge clk) begin : model
      bit e_ren, e_valid;
      if (!rst_n) begin
         m_active = 0; m_need = 0; m_pending = 0; m_wrap = 0; m_count = 0; m_cyc = 0;
         checks++;
         if ({PC_address, rEn, ins_valid, instruction, pc_out, busy, pc_wrap, fetch_count} !== '0) begin
            failures++;
            $display("[TB] FAIL model_reset got=%h exp=0",
                     {PC_address, rEn, ins_valid, instruction, pc_out, busy, pc_wrap, fetch_count});
         end
      end else begin
         m_cyc++;
         e_ren   = m_need && (m_cyc >= m_fetch_due);
         e_valid = m_pending && (m_cyc >= m_valid_due);
         checks++;
         if (rEn !== e_ren) begin
            failures++; $display("[TB] FAIL model_rEn cyc=%0d got=%b exp=%b", m_cyc, rEn, e_ren);
         end
         if (e_ren) begin
            checks++;
            if (PC_address !== m_pc) begin
               failures++; $display("[TB] FAIL model_addr cyc=%0d got=%h exp=%h", m_cyc, PC_address, m_pc);
            end
         end
         checks++;
         if (ins_valid !== e_valid) begin
            failures++; $display("[TB] FAIL model_valid cyc=%0d got=%b exp=%b", m_cyc, ins_valid, e_valid);
         end
         if (e_valid) begin
            checks++;
            if (instruction !== mem[m_fetched] || pc_out !== m_fetched) begin
               failures++;
               $display("[TB] FAIL model_data cyc=%0d got=%h@%h exp=%h@%h",
                        m_cyc, instruction, pc_out, mem[m_fetched], m_fetched);
            end
         end
         checks++;
         if (busy !== m_active || fetch_count !== CW'(m_count) || pc_wrap !== m_wrap) begin
            failures++;
            $display("[TB] FAIL model_status cyc=%0d got busy=%b cnt=%0d wrap=%b exp busy=%b cnt=%0d wrap=%b",
                     m_cyc, busy, fetch_count, pc_wrap, m_active, m_count, m_wrap);
         end
         if (e_ren) begin
            m_need = 0; m_fetched = m_pc; m_pending = 1; m_valid_due = m_cyc + 2;
         end
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_need = 1; m_fetch_due = m_cyc + 1; m_pc = 8'h00;
               m_count = 0; m_wrap = 0; m_pending = 0;
            end
         end else if (flush) begin
            m_need = 1; m_fetch_due = m_cyc + 1; m_pc = flush_target; m_pending = 0;
         end else if (e_valid && ins_ready) begin
            if (m_count < CNT_MAX) m_count++;
            m_pending = 0;
            if (halt) begin
               m_active = 0;
            end else begin
               m_need = 1; m_fetch_due = m_cyc + 1;
               if (branch_en) begin
                  m_pc = branch_target;
               end else begin
                  if (m_fetched == 8'hFF) m_wrap = 1;
                  m_pc = m_fetched + 8'd1;
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (rEn !== 1'b0 || busy !== 1'b0 || ins_valid !== 1'b0 || PC_address !== 8'h00) begin
         failures++; $display("[TB] FAIL reset_state got rEn=%b busy=%b valid=%b addr=%h exp 0 0 0 00", rEn, busy, ins_valid, PC_address);
      end
      rst_n = 1'b1;
      tick(3);
      checks++;
      if (rEn !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL idle_after_reset got rEn=%b busy=%b exp 0 0", rEn, busy);
      end
   endtask

   task automatic test_basic();
      ins_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (rEn !== 1'b1 || PC_address !== 8'h00) begin
         failures++; $display("[TB] FAIL first_req got rEn=%b addr=%h exp 1 00", rEn, PC_address);
      end
      tick(2);
      checks++;
      if (ins_valid !== 1'b1 || instruction !== 9'h101 || pc_out !== 8'h00) begin
         failures++; $display("[TB] FAIL first_ins got v=%b ins=%h pc=%h exp 1 101 00", ins_valid, instruction, pc_out);
      end
      tick(3);
      checks++;
      if (ins_valid !== 1'b1 || instruction !== 9'h102 || pc_out !== 8'h01) begin
         failures++; $display("[TB] FAIL second_ins got v=%b ins=%h pc=%h exp 1 102 01", ins_valid, instruction, pc_out);
      end
      tick();
      checks++;
      if (fetch_count !== 4'd2) begin
         failures++; $display("[TB] FAIL count_two got=%0d exp=2", fetch_count);
      end
   endtask

   task automatic test_backpressure();
      ins_ready = 1'b0;
      tick(2);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ins_valid !== 1'b1 || instruction !== 9'h103 || pc_out !== 8'h02 || rEn !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_hold got v=%b ins=%h pc=%h rEn=%b exp 1 103 02 0", ins_valid, instruction, pc_out, rEn);
         end
      end
      ins_ready = 1'b1;
      tick();
      checks++;
      if (fetch_count !== 4'd3 || ins_valid !== 1'b0 || rEn !== 1'b1 || PC_address !== 8'h03) begin
         failures++; $display("[TB] FAIL stall_release got cnt=%0d v=%b rEn=%b addr=%h exp 3 0 1 03", fetch_count, ins_valid, rEn, PC_address);
      end
   endtask

   task automatic test_branch_halt();
      tick(2);
      branch_en = 1'b1; branch_target = 8'h40;
      tick();
      branch_en = 1'b0;
      checks++;
      if (rEn !== 1'b1 || PC_address !== 8'h40) begin
         failures++; $display("[TB] FAIL branch_addr got rEn=%b addr=%h exp 1 40", rEn, PC_address);
      end
      tick(2);
      halt = 1'b1; branch_en = 1'b1; branch_target = 8'h22;
      tick();
      halt = 1'b0; branch_en = 1'b0;
      checks++;
      if (busy !== 1'b0 || ins_valid !== 1'b0 || fetch_count !== 4'd5) begin
         failures++; $display("[TB] FAIL halt_state got busy=%b v=%b cnt=%0d exp 0 0 5", busy, ins_valid, fetch_count);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (rEn !== 1'b0) begin
            failures++; $display("[TB] FAIL halt_no_fetch got=%b exp=0", rEn);
         end
      end
   endtask

   task automatic test_flush();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (fetch_count !== 4'd0 || rEn !== 1'b1 || PC_address !== 8'h00) begin
         failures++; $display("[TB] FAIL restart got cnt=%0d rEn=%b addr=%h exp 0 1 00", fetch_count, rEn, PC_address);
      end
      tick();
      flush = 1'b1; flush_target = 8'h10;
      tick();
      flush = 1'b0;
      checks++;
      if (ins_valid !== 1'b0 || rEn !== 1'b1 || PC_address !== 8'h10) begin
         failures++; $display("[TB] FAIL flush_resp got v=%b rEn=%b addr=%h exp 0 1 10", ins_valid, rEn, PC_address);
      end
      tick(2);
      checks++;
      if (ins_valid !== 1'b1 || pc_out !== 8'h10 || instruction !== mem[8'h10]) begin
         failures++; $display("[TB] FAIL flush_target_ins got v=%b pc=%h ins=%h exp 1 10 %h", ins_valid, pc_out, instruction, mem[8'h10]);
      end
      flush = 1'b1; flush_target = 8'h20; halt = 1'b1;
      tick();
      flush = 1'b0; halt = 1'b0;
      checks++;
      if (fetch_count !== 4'd0 || rEn !== 1'b1 || PC_address !== 8'h20 || busy !== 1'b1) begin
         failures++; $display("[TB] FAIL flush_hold got cnt=%0d rEn=%b addr=%h busy=%b exp 0 1 20 1", fetch_count, rEn, PC_address, busy);
      end
   endtask

   task automatic test_wrap();
      tick(2);
      branch_en = 1'b1; branch_target = 8'hFF;
      tick();
      branch_en = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (pc_out !== 8'hFF || ins_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL wrap_top got pc=%h v=%b exp FF 1", pc_out, ins_valid);
      end
      tick();
      checks++;
      if (PC_address !== 8'h00 || rEn !== 1'b1 || pc_wrap !== 1'b1) begin
         failures++; $display("[TB] FAIL wrap_step got addr=%h rEn=%b wrap=%b exp 00 1 1", PC_address, rEn, pc_wrap);
      end
      tick(2);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++;
      if (pc_wrap !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL wrap_sticky got wrap=%b busy=%b exp 1 0", pc_wrap, busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (pc_wrap !== 1'b0) begin
         failures++; $display("[TB] FAIL wrap_clear got=%b exp=0", pc_wrap);
      end
   endtask

   task automatic test_async_reset();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({PC_address, rEn, ins_valid, instruction, pc_out, busy, pc_wrap, fetch_count} !== '0) begin
         failures++;
         $display("[TB] FAIL async_reset got=%h exp=0", {PC_address, rEn, ins_valid, instruction, pc_out, busy, pc_wrap, fetch_count});
      end
      tick(2);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (rEn !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset_idle got rEn=%b busy=%b exp 0 0", rEn, busy);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         ins_ready     = ($urandom_range(9) < 6);
         branch_en     = ($urandom_range(3) == 0);
         branch_target = ($urandom_range(7) == 0) ? 8'hFF : AW'($urandom);
         halt          = ($urandom_range(24) == 0);
         flush         = ($urandom_range(19) == 0);
         flush_target  = AW'($urandom);
         start         = m_active ? ($urandom_range(29) == 0) : ($urandom_range(2) == 0);
         tick();
      end
      {start, flush, halt, branch_en, ins_ready} = '0;
      tick(4);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
      mem[0] = 9'h101; mem[1] = 9'h102; mem[2] = 9'h103; mem[3] = 9'h104;
      mem_instruction = '0;
      rst_n = 1'b0;
      {start, flush, halt, branch_en, ins_ready} = '0;
      flush_target = '0; branch_target = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_branch_halt();
      test_flush();
      test_wrap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
